// File: rtl/floo_pkg.sv
// Shared floo link-buffer types and constants.
package floo_pkg;

    localparam int unsigned LinkBufferDefaultDepth = 4;
    // Widest occupancy count for the largest legal depth (64 entries)
    localparam int unsigned LinkBufferMaxCntWidth  = 7;

    typedef struct packed {
        logic [31:0]                      flit_cnt;
        logic [31:0]                      stall_cnt;
        logic [LinkBufferMaxCntWidth-1:0] max_usage;
    } link_buffer_stats_t;

endpackage

// File: rtl/floo_link_stats_cnt.sv
// Saturating 32-bit event counter with enable and synchronous reset.
module floo_link_stats_cnt (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    output logic [31:0] cnt_o
);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (en_i && (cnt_o != 32'hFFFF_FFFF)) begin
            cnt_o <= cnt_o + 32'd1;
        end
    end

endmodule

// File: rtl/floo_wide_only_link_buffer.sv
// Elastic in-order flit buffer between two wide-only chimneys.
// Optional statistics outputs are enabled with FLOO_LINK_BUFFER_STATS_EN.
module floo_wide_only_link_buffer
    import floo_pkg::*;
#(
    parameter type         flit_t   = logic,
    parameter int unsigned Depth    = LinkBufferDefaultDepth,
    parameter int unsigned CntWidth = $clog2(Depth) + 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  flit_t               data_i,
    output logic                valid_o,
    input  logic                ready_i,
    output flit_t               data_o,
    output logic [CntWidth-1:0] usage_o,
    output logic                full_o,
    output logic                empty_o
`ifdef FLOO_LINK_BUFFER_STATS_EN
    ,
    output logic [31:0]         flit_cnt_o,
    output logic [31:0]         stall_cnt_o,
    output logic [CntWidth-1:0] max_usage_o
`endif
);

    localparam int unsigned PtrWidth = $clog2(Depth);

    flit_t               mem_q [Depth];
    logic [PtrWidth-1:0] rd_ptr_q;
    logic [PtrWidth-1:0] wr_ptr_q;
    logic [CntWidth-1:0] count_q;
    logic                push;
    logic                pop;

    // Handshake flags depend only on the count register, never on ready_i
    assign full_o  = (count_q == CntWidth'(Depth));
    assign empty_o = (count_q == '0);
    assign ready_o = !full_o;
    assign valid_o = !empty_o;
    assign usage_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign push = valid_i && ready_o;
    assign pop  = valid_o && ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + PtrWidth'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrWidth'(1);
            end
            count_q <= count_q + CntWidth'(push) - CntWidth'(pop);
        end
    end

`ifdef FLOO_LINK_BUFFER_STATS_EN
    logic [31:0]         flit_cnt;
    logic [31:0]         stall_cnt;
    logic [CntWidth-1:0] max_usage_q;
    link_buffer_stats_t  stats;

    floo_link_stats_cnt u_flit_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (pop),
        .cnt_o (flit_cnt)
    );

    floo_link_stats_cnt u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (valid_o && !ready_i),
        .cnt_o (stall_cnt)
    );

    // High-water mark survives flush; only reset clears it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            max_usage_q <= '0;
        end else if (count_q > max_usage_q) begin
            max_usage_q <= count_q;
        end
    end

    assign stats = '{
        flit_cnt:  flit_cnt,
        stall_cnt: stall_cnt,
        max_usage: LinkBufferMaxCntWidth'(max_usage_q)
    };

    assign flit_cnt_o  = stats.flit_cnt;
    assign stall_cnt_o = stats.stall_cnt;
    assign max_usage_o = CntWidth'(stats.max_usage);
`endif

`ifndef SYNTHESIS
    logic  in_stall_q;
    logic  out_stall_q;
    flit_t data_in_q;
    flit_t data_out_q;

    // Occupancy bounds and valid/data stability on both sides
    always_ff @(posedge clk_i) begin
        data_in_q  <= data_i;
        data_out_q <= data_o;
        if (rst_i) begin
            in_stall_q  <= 1'b0;
            out_stall_q <= 1'b0;
        end else begin
            in_stall_q  <= valid_i && !ready_o;
            out_stall_q <= valid_o && !ready_i && !flush_i;
            if (!flush_i) begin
                assert (!(push && !pop && full_o))
                    else $error("link buffer count overflow");
                assert (!(pop && !push && empty_o))
                    else $error("link buffer count underflow");
            end
            if (in_stall_q) begin
                assert (valid_i && (data_i == data_in_q))
                    else $error("upstream dropped or changed a stalled flit");
            end
            if (out_stall_q) begin
                assert (valid_o && (data_o == data_out_q))
                    else $error("downstream flit changed while stalled");
            end
        end
    end
`endif

endmodule

// File: tb/tb_floo_wide_only_link_buffer.sv
// Randomized scoreboard bench for floo_wide_only_link_buffer (queue-based reference model).
module tb_floo_wide_only_link_buffer;

    typedef logic [15:0] flit_t;
    localparam int unsigned Depth    = 4;
    localparam int unsigned CntWidth = 3;

    logic                clk_i;
    logic                rst_i;
    logic                flush_i;
    logic                valid_i;
    logic                ready_o;
    flit_t               data_i;
    logic                valid_o;
    logic                ready_i;
    flit_t               data_o;
    logic [CntWidth-1:0] usage_o;
    logic                full_o;
    logic                empty_o;
`ifdef FLOO_LINK_BUFFER_STATS_EN
    logic [31:0]         flit_cnt_o;
    logic [31:0]         stall_cnt_o;
    logic [CntWidth-1:0] max_usage_o;
`endif

    floo_wide_only_link_buffer #(
        .flit_t (flit_t),
        .Depth  (Depth)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .usage_o (usage_o),
        .full_o  (full_o),
        .empty_o (empty_o)
`ifdef FLOO_LINK_BUFFER_STATS_EN
        ,
        .flit_cnt_o  (flit_cnt_o),
        .stall_cnt_o (stall_cnt_o),
        .max_usage_o (max_usage_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffer is an ordered queue of at most Depth flits
    flit_t q[$];
    bit    model_on  = 0;
    bit    zero_data = 0;
    int    pushes    = 0;
    int    pops      = 0;
    int    m_pops    = 0;
    int    m_stalls  = 0;
    int    m_max     = 0;

    always @(negedge clk_i) begin
        if (model_on) begin
            chk("usage_o", 32'(usage_o), 32'(q.size()));
            chk("valid_o", 32'(valid_o), 32'(q.size() > 0));
            chk("ready_o", 32'(ready_o), 32'(q.size() < Depth));
            chk("full_o",  32'(full_o),  32'(q.size() == Depth));
            chk("empty_o", 32'(empty_o), 32'(q.size() == 0));
            if (q.size() > 0)
                chk("data_o", 32'(data_o), 32'(q[0]));
            else if (zero_data)
                chk("data_o_reset", 32'(data_o), 32'd0);
`ifdef FLOO_LINK_BUFFER_STATS_EN
            chk("flit_cnt_o",  flit_cnt_o,  32'(m_pops));
            chk("stall_cnt_o", stall_cnt_o, 32'(m_stalls));
            chk("max_usage_o", 32'(max_usage_o), 32'(m_max));
`endif
        end
        if (rst_i) begin
            q.delete();
            model_on  = 1;
            zero_data = 1;
            m_pops    = 0;
            m_stalls  = 0;
            m_max     = 0;
        end else if (model_on) begin
            bit can_push;
            can_push = valid_i && (q.size() < Depth);
            if (q.size() > m_max) m_max = q.size();
            if (q.size() > 0 && !ready_i) m_stalls++;
            if (q.size() > 0 && ready_i) begin
                void'(q.pop_front());
                pops++;
                m_pops++;
            end
            if (flush_i) begin
                q.delete();
            end else if (can_push) begin
                q.push_back(data_i);
                pushes++;
                zero_data = 0;
            end
        end
    end

    task automatic send(input flit_t d);
        int n;
        n = 0;
        valid_i = 1'b1;
        data_i  = d;
        @(negedge clk_i);
        while (!ready_o && n < 100) begin
            n++;
            @(negedge clk_i);
        end
        if (n >= 100) chk("send_timeout", 32'd0, 32'd1);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        int r0;
        bit acc;
        rst_i   = 1'b1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = '0;

        // Reset then idle
        cycles(3);
        rst_i = 1'b0;
        cycles(10);
        @(negedge clk_i);
        chk("idle_data_o", 32'(data_o), 32'd0);
        chk("idle_ready_o", 32'(ready_o), 32'd1);
        @(posedge clk_i); #1;

        // Fill and drain, including simultaneous push and pop at full
        for (int k = 1; k <= 4; k++) send(flit_t'(k * 17));
        @(negedge clk_i);
        chk("fill_full_o", 32'(full_o), 32'd1);
        chk("fill_ready_o", 32'(ready_o), 32'd0);
        @(posedge clk_i); #1;
        fork
            send(16'h0055);
            begin
                cycles(2);
                ready_i = 1'b1;
                @(negedge clk_i);
                chk("full_pop_head", 32'(data_o), 32'h11);
                @(negedge clk_i);
                chk("full_pop_usage", 32'(usage_o), 32'd3);
            end
        join
        cycles(8);
        chk("drain_empty_o", 32'(empty_o), 32'd1);

        // Streaming at full throughput with pointer wrap
        p0 = pushes;
        r0 = pops;
        ready_i = 1'b1;
        valid_i = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            data_i = flit_t'($urandom);
            cycles(1);
        end
        valid_i = 1'b0;
        cycles(3);
        chk("stream_pushes", 32'(pushes - p0), 32'd1000);
        chk("stream_pops", 32'(pops - r0), 32'd1000);

        // Random valid/ready with hold-until-accepted upstream
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_i);
            acc = valid_i && ready_o;
            @(posedge clk_i);
            #1;
            if (!valid_i || acc) begin
                valid_i = ($urandom_range(0, 3) != 0);
                data_i  = flit_t'($urandom);
            end
            ready_i = ($urandom_range(0, 2) != 0);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        cycles(10);

        // Flush with 3 stored and a concurrent push
        ready_i = 1'b0;
        send(16'h00A1);
        send(16'h00A2);
        send(16'h00A3);
        valid_i = 1'b1;
        data_i  = 16'h0BAD;
        flush_i = 1'b1;
        cycles(1);
        flush_i = 1'b0;
        valid_i = 1'b0;
        @(negedge clk_i);
        chk("flush_usage", 32'(usage_o), 32'd0);
        @(posedge clk_i); #1;
        ready_i = 1'b1;
        cycles(5);
        chk("flush_valid_o", 32'(valid_o), 32'd0);

        // Reset with 2 flits stored
        ready_i = 1'b0;
        send(16'h00B1);
        send(16'h00B2);
        rst_i = 1'b1;
        cycles(1);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_valid_o", 32'(valid_o), 32'd0);
        chk("rst_ready_o", 32'(ready_o), 32'd1);
        chk("rst_usage_o", 32'(usage_o), 32'd0);
        chk("rst_data_o", 32'(data_o), 32'd0);
        @(posedge clk_i); #1;

`ifdef FLOO_LINK_BUFFER_STATS_EN
        // Stats: 10 pops with stalled cycles in between
        for (int k = 0; k < 3; k++) send(flit_t'(16'h0C00 + k));
        cycles(4);
        ready_i = 1'b1;
        for (int k = 3; k < 10; k++) send(flit_t'(16'h0C00 + k));
        cycles(6);
        chk("stats_flit_cnt", flit_cnt_o, 32'd10);
`endif

        cycles(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
